adpll_lock_ctrl: RTL and testbench
==================================

// Module: adpll_lock_ctrl
// PURPOSE
//  Acquisition/lock sequencer for the adpll core. Measures the phase error between the
//  reference (i_rf) and the adpll output (i_gen) once per reference period, drives the
//  adpll loop-gain step (o_step) and its reset (o_adpll_rst). It sequences the loop through
//  coarse and fine acquisition into lock, and retries on timeout or reference loss.
// PARAMETERS
//  CNT_W        12     width of the period/age counters; they saturate at all-ones
//  RST_CYC      16     clk cycles o_adpll_rst is held per reset episode
//  STEP_COARSE  8'h10  o_step value in COARSE
//  STEP_FINE    8'h02  o_step value in FINE and LOCKED
//  COARSE_TOL   16     |err| limit for leaving COARSE (clk cycles)
//  LOCK_TOL     2      |err| limit for declaring lock
//  UNLOCK_TOL   8      |err| above this counts toward unlock
//  LOCK_CNT     8      consecutive in-tolerance periods needed (COARSE->FINE, FINE->LOCKED)
//  UNLOCK_CNT   4      consecutive out-of-tolerance periods in LOCKED before unlock
//  ACQ_TIMEOUT  64     max ref periods spent in COARSE+FINE before retry
//  RF_TIMEOUT   1024   clk cycles with no i_rf rise => reference lost
// PORTS
//  i_clk        in   1      system clock
//  i_rst_n      in   1      asynchronous reset, active-low
//  i_en         in   1      enable; low forces IDLE
//  i_rf         in   1      reference clock, asynchronous; 2-FF synchronised internally
//  i_gen        in   1      adpll o_gen feedback, asynchronous; 2-FF synchronised internally
//  o_step       out  8      loop step to adpll i_step
//  o_adpll_rst  out  1      active-high reset to adpll i_rst
//  o_locked     out  1      high only in LOCKED
//  o_state      out  3      IDLE=0 RST=1 COARSE=2 FINE=3 LOCKED=4
//  o_err        out  CNT_W  last phase-error magnitude (clk cycles)
//  o_retry      out  1      one-cycle pulse on every timeout/ref-loss re-entry to RST
// BEHAVIOUR
//  Reset: state=IDLE, o_step=0, o_adpll_rst=1, o_locked=0, o_err=0, o_retry=0, counters=0.
//  All outputs registered. Edge detection: rise = sync & ~sync_d (3 clk after the pin).
//  period_cnt: +1/clk, saturating; on rf rise, period<=period_cnt+1, period_cnt<=0.
//  gen_age: +1/clk, saturating; cleared on gen rise (a gen rise in the same cycle as an rf rise
//   is sampled as age 0).
//  On rf rise with valid period: err = (gen_age <= period>>1) ? gen_age : period-gen_age;
//   o_err updates the next cycle. The first rf rise after leaving RST only loads period (no
//   err evaluated, no counters touched).
//  IDLE: o_step=0, o_adpll_rst=1. i_en=1 -> RST.
//  RST: o_adpll_rst=1, o_step=0 for RST_CYC cycles; exit to COARSE only once RST_CYC has
//   elapsed AND at least one rf rise has been seen in RST.
//  COARSE: step=STEP_COARSE. good_cnt++ when err<=COARSE_TOL, else cleared; at LOCK_CNT -> FINE.
//  FINE: step=STEP_FINE. good_cnt++ when err<=LOCK_TOL, else cleared; at LOCK_CNT -> LOCKED.
//  acq_cnt counts evaluated periods across COARSE+FINE; reaching ACQ_TIMEOUT -> RST,
//   o_retry pulse. acq_cnt is cleared on entry to COARSE from RST (not on COARSE->FINE).
//  LOCKED: o_locked=1, step=STEP_FINE. bad_cnt++ when err>UNLOCK_TOL, else cleared;
//   at UNLOCK_CNT -> FINE (acq_cnt cleared, o_locked falls the same cycle as the state change).
//  good_cnt/bad_cnt are cleared on every state change.
//  Ref loss: period_cnt reaching RF_TIMEOUT in COARSE/FINE/LOCKED -> RST with o_retry.
//   In RST, ref loss only blocks exit (no retry pulse).
//  i_en=0 in any state -> IDLE next cycle (highest priority, over timeout and ref loss).
//  Priority inside one cycle: i_en=0 > ref loss > acq timeout > lock/unlock transition.
//  Mid-operation i_rst_n assertion: immediate return to the reset values; o_adpll_rst asserts
//   asynchronously.
// TESTING
//  1 Reset; i_en=1; rf period 256 clk; gen in phase (err 0) -> o_adpll_rst high 16 clk,
//    COARSE after first rf rise, FINE after 8 periods, LOCKED after 8 more; o_step 0->10->02.
//  2 Locked; shift gen by 20 clk for 4 periods -> o_locked falls after the 4th, state FINE;
//    restore phase -> LOCKED after 8 periods.
//  3 gen held 100 clk off (err 100) -> stays COARSE; after 64 evaluated periods, RST and a
//    single o_retry pulse; cycle repeats.
//  4 Locked, stop i_rf -> RST 1024 clk after the last rise, o_retry=1, o_locked=0; RST held
//    until i_rf resumes.
//  5 Drop i_en in FINE while a ref-loss timeout is due that cycle -> IDLE, o_retry stays 0,
//    o_step=0.
//  6 Pulse i_rst_n low mid-COARSE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/adpll_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// adpll_lock_ctrl: per-reference-period phase-error measurement and the
// IDLE/RST/COARSE/FINE/LOCKED sequencer driving the adpll step and reset.
module adpll_lock_ctrl #(
  parameter int         CNT_W       = 12,
  parameter int         RST_CYC     = 16,
  parameter logic [7:0] STEP_COARSE = 8'h10,
  parameter logic [7:0] STEP_FINE   = 8'h02,
  parameter int         COARSE_TOL  = 16,
  parameter int         LOCK_TOL    = 2,
  parameter int         UNLOCK_TOL  = 8,
  parameter int         LOCK_CNT    = 8,
  parameter int         UNLOCK_CNT  = 4,
  parameter int         ACQ_TIMEOUT = 64,
  parameter int         RF_TIMEOUT  = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_rf,
  input  logic             i_gen,
  output logic [7:0]       o_step,
  output logic             o_adpll_rst,
  output logic             o_locked,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_err,
  output logic             o_retry
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam int GW = $clog2(((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT) + 1);
  localparam int AW = $clog2(ACQ_TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] C_COARSE_TOL = CNT_W'(COARSE_TOL);
  localparam logic [CNT_W-1:0] C_LOCK_TOL   = CNT_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0] C_UNLOCK_TOL = CNT_W'(UNLOCK_TOL);
  localparam logic [CNT_W-1:0] C_RF_TO      = CNT_W'(RF_TIMEOUT);
  localparam logic [GW-1:0]    LOCK_LAST    = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0]    UNLOCK_LAST  = GW'(UNLOCK_CNT - 1);
  localparam logic [AW-1:0]    ACQ_LAST     = AW'(ACQ_TIMEOUT - 1);
  localparam logic [RW-1:0]    RST_LAST     = RW'(RST_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       rf_sync_q, gen_sync_q;
  logic [CNT_W-1:0] period_cnt_q, period_q, gen_age_q;
  logic [GW-1:0]    good_q, good_d, bad_q, bad_d;
  logic [AW-1:0]    acq_q, acq_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic             rf_seen_q, rf_seen_d, vld_q;
  logic             retry_d;
  logic [7:0]       step_d;

  logic             rf_rise, gen_rise, active, eval, ref_lost;
  logic [CNT_W-1:0] age, err, tol;

  assign rf_rise  = rf_sync_q[1] & ~rf_sync_q[2];
  assign gen_rise = gen_sync_q[1] & ~gen_sync_q[2];
  assign active   = (state_q == ST_COARSE) || (state_q == ST_FINE) || (state_q == ST_LOCKED);
  assign eval     = rf_rise & vld_q & active;
  assign ref_lost = (period_cnt_q >= C_RF_TO);
  // Age is counted in clk cycles since the gen rise; a coincident gen rise means zero.
  assign age      = gen_rise ? '0 : sat_inc(gen_age_q);
  assign err      = (age <= (period_q >> 1)) ? age : period_q - age;
  assign tol      = (state_q == ST_COARSE) ? C_COARSE_TOL : C_LOCK_TOL;

  always_comb begin
    state_d   = state_q;
    retry_d   = 1'b0;
    good_d    = good_q;
    bad_d     = bad_q;
    acq_d     = acq_q;
    rst_cnt_d = '0;
    rf_seen_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_RST;
      end
      ST_RST: begin
        rst_cnt_d = (rst_cnt_q == RST_LAST) ? rst_cnt_q : rst_cnt_q + 1'b1;
        rf_seen_d = rf_seen_q | rf_rise;
        if ((rst_cnt_q == RST_LAST) && rf_seen_q && !ref_lost) begin
          state_d = ST_COARSE;
          acq_d   = '0;
        end
      end
      ST_COARSE, ST_FINE: begin
        if (ref_lost) begin
          state_d = ST_RST;
          retry_d = 1'b1;
        end else if (eval) begin
          acq_d = acq_q + 1'b1;
          if (acq_q == ACQ_LAST) begin
            state_d = ST_RST;
            retry_d = 1'b1;
          end else if (err <= tol) begin
            good_d = good_q + 1'b1;
            if (good_q == LOCK_LAST)
              state_d = (state_q == ST_COARSE) ? ST_FINE : ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (ref_lost) begin
          state_d = ST_RST;
          retry_d = 1'b1;
        end else if (eval) begin
          if (err > C_UNLOCK_TOL) begin
            bad_d = bad_q + 1'b1;
            if (bad_q == UNLOCK_LAST) begin
              state_d = ST_FINE;
              acq_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_en) begin
      state_d = ST_IDLE;
      retry_d = 1'b0;
    end
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_comb begin
    step_d = 8'h00;
    case (state_d)
      ST_COARSE:         step_d = STEP_COARSE;
      ST_FINE, ST_LOCKED: step_d = STEP_FINE;
      default:           step_d = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rf_sync_q    <= '0;
      gen_sync_q   <= '0;
      period_cnt_q <= '0;
      period_q     <= '0;
      gen_age_q    <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      acq_q        <= '0;
      rst_cnt_q    <= '0;
      rf_seen_q    <= 1'b0;
      vld_q        <= 1'b0;
      o_step       <= 8'h00;
      o_adpll_rst  <= 1'b1;
      o_locked     <= 1'b0;
      o_state      <= 3'd0;
      o_err        <= '0;
      o_retry      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_sync_q    <= {rf_sync_q[1:0], i_rf};
      gen_sync_q   <= {gen_sync_q[1:0], i_gen};
      period_cnt_q <= rf_rise ? '0 : sat_inc(period_cnt_q);
      if (rf_rise) period_q <= sat_inc(period_cnt_q);
      gen_age_q    <= gen_rise ? '0 : sat_inc(gen_age_q);
      good_q       <= good_d;
      bad_q        <= bad_d;
      acq_q        <= acq_d;
      rst_cnt_q    <= rst_cnt_d;
      rf_seen_q    <= rf_seen_d;
      // The first rf rise after leaving RST only primes the period measurement.
      vld_q        <= active & (vld_q | rf_rise);
      o_step       <= step_d;
      o_adpll_rst  <= (state_d == ST_IDLE) || (state_d == ST_RST);
      o_locked     <= (state_d == ST_LOCKED);
      o_state      <= state_d;
      if (eval) o_err <= err;
      o_retry      <= retry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adpll_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_adpll_lock_ctrl: directed scenarios for the adpll lock sequencer with
// hand-derived expected states, timings and error values.
module tb_adpll_lock_ctrl;

  localparam int PER = 256;
  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_COARSE = 3'd2,
                         S_FINE = 3'd3, S_LOCKED = 3'd4;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, rf = 1'b0, gen = 1'b0;
  logic [7:0]  step;
  logic        adpll_rst, locked, retry;
  logic [2:0]  state;
  logic [11:0] err;

  int checks = 0, failures = 0;
  int cyc = 0;
  int ph = PER - 1;
  bit rf_run = 1'b0;
  int gen_off = 0, gen_off_nxt = 0;
  int rf_rises = 0, last_rise_cyc = 0, retry_seen = 0;

  adpll_lock_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rf(rf), .i_gen(gen),
    .o_step(step), .o_adpll_rst(adpll_rst), .o_locked(locked),
    .o_state(state), .o_err(err), .o_retry(retry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (retry === 1'b1) retry_seen = retry_seen + 1;

  // Reference / feedback generator; a new gen offset takes effect on an rf rise.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_run) begin
        ph = (ph + 1) % PER;
        if (ph == 0) begin
          gen_off = gen_off_nxt;
          rf_rises = rf_rises + 1;
          last_rise_cyc = cyc;
        end
        rf  = (ph < PER / 2);
        gen = (((ph - gen_off + PER) % PER) < PER / 2);
      end else begin
        rf = 1'b0; gen = 1'b0; ph = PER - 1;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state === s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset(input int off);
    @(negedge clk);
    en = 1'b0; rf_run = 1'b0; gen_off_nxt = off; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(0);
    checks++;
    if ({state, step, adpll_rst, locked, err, retry} !== {S_IDLE, 8'h00, 1'b1, 1'b0, 12'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got st=%0d step=%h arst=%b lk=%b err=%0d rty=%b exp 0/00/1/0/0/0",
               state, step, adpll_rst, locked, err, retry);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (state !== S_IDLE) begin failures++; $display("FAIL idle_hold got=%0d exp=%0d", state, S_IDLE); end
  endtask

  task automatic test_acquire;
    bit ok; int n_rst, base;
    do_reset(0);
    en = 1'b1; rf_run = 1'b1;
    wait_state(S_RST, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL enter_rst got=%0d exp=%0d", state, S_RST); end
    n_rst = 0;
    for (int i = 0; i < 2000 && state === S_RST; i++) begin
      if (adpll_rst === 1'b1 && step === 8'h00) n_rst++;
      @(negedge clk);
    end
    checks++;
    if (n_rst !== 16) begin failures++; $display("FAIL rst_hold_cycles got=%0d exp=16", n_rst); end
    checks++;
    if ({state, step, adpll_rst} !== {S_COARSE, 8'h10, 1'b0}) begin
      failures++; $display("FAIL coarse_entry got st=%0d step=%h arst=%b exp 2/10/0", state, step, adpll_rst);
    end
    base = rf_rises;
    wait_state(S_FINE, 12 * PER, ok);
    checks++;
    if (!ok || (rf_rises - base) !== 9) begin
      failures++; $display("FAIL coarse_to_fine got ok=%0d rises=%0d exp ok=1 rises=9", ok, rf_rises - base);
    end
    checks++;
    if (step !== 8'h02) begin failures++; $display("FAIL fine_step got=%h exp=02", step); end
    base = rf_rises;
    wait_state(S_LOCKED, 11 * PER, ok);
    checks++;
    if (!ok || (rf_rises - base) !== 8) begin
      failures++; $display("FAIL fine_to_locked got ok=%0d rises=%0d exp ok=1 rises=8", ok, rf_rises - base);
    end
    checks++;
    if ({locked, step, err} !== {1'b1, 8'h02, 12'd0}) begin
      failures++; $display("FAIL locked_outputs got lk=%b step=%h err=%0d exp 1/02/0", locked, step, err);
    end
  endtask

  task automatic test_unlock;
    bit ok; int base;
    gen_off_nxt = 20;
    base = rf_rises;
    for (int i = 0; i < 2 * PER && rf_rises == base; i++) @(negedge clk);
    base = rf_rises;
    wait_state(S_FINE, 6 * PER, ok);
    checks++;
    if (!ok || (rf_rises - base) !== 4) begin
      failures++; $display("FAIL unlock_after got ok=%0d rises=%0d exp ok=1 rises=4", ok, rf_rises - base);
    end
    checks++;
    if ({locked, err} !== {1'b0, 12'd20}) begin
      failures++; $display("FAIL unlock_outputs got lk=%b err=%0d exp 0/20", locked, err);
    end
    gen_off_nxt = 0;
    base = rf_rises;
    for (int i = 0; i < 2 * PER && rf_rises == base; i++) @(negedge clk);
    base = rf_rises;
    // The restoring rf rise itself is the first of the eight good periods.
    wait_state(S_LOCKED, 10 * PER, ok);
    checks++;
    if (!ok || (rf_rises - base) !== 7 || locked !== 1'b1 || err !== 12'd0) begin
      failures++; $display("FAIL relock got ok=%0d rises=%0d lk=%b err=%0d exp 1/7/1/0", ok, rf_rises - base, locked, err);
    end
  endtask

  task automatic test_acq_timeout;
    bit ok; int base, r0;
    do_reset(100);
    en = 1'b1; rf_run = 1'b1;
    wait_state(S_COARSE, 300, ok);
    r0 = retry_seen;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (!ok) begin failures++; $display("FAIL timeout_coarse_%0d got=%0d exp=%0d", k, state, S_COARSE); end
      base = rf_rises;
      wait_state(S_RST, 70 * PER, ok);
      checks++;
      if (!ok || (rf_rises - base) !== 65 || retry !== 1'b1) begin
        failures++; $display("FAIL timeout_retry_%0d got ok=%0d rises=%0d rty=%b exp 1/65/1", k, ok, rf_rises - base, retry);
      end
      checks++;
      if (err !== 12'd100) begin failures++; $display("FAIL timeout_err got=%0d exp=100", err); end
      repeat (3) @(negedge clk);
      checks++;
      if ((retry_seen - r0) !== k) begin failures++; $display("FAIL retry_pulses got=%0d exp=%0d", retry_seen - r0, k); end
      if (k == 1) wait_state(S_COARSE, 300, ok);
    end
  endtask

  task automatic test_ref_loss;
    bit ok; int lr, r0;
    do_reset(0);
    en = 1'b1; rf_run = 1'b1;
    wait_state(S_LOCKED, 24 * PER, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL refloss_lock got=%0d exp=%0d", state, S_LOCKED); end
    rf_run = 1'b0;
    lr = last_rise_cyc;
    r0 = retry_seen;
    wait_state(S_RST, 1100, ok);
    checks++;
    if (!ok || (cyc - lr) !== 1028) begin
      failures++; $display("FAIL refloss_time got ok=%0d dt=%0d exp ok=1 dt=1028", ok, cyc - lr);
    end
    checks++;
    if ({retry, locked, adpll_rst, step} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      failures++; $display("FAIL refloss_outputs got rty=%b lk=%b arst=%b step=%h exp 1/0/1/00", retry, locked, adpll_rst, step);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (state !== S_RST || (retry_seen - r0) !== 1) begin
      failures++; $display("FAIL refloss_hold got st=%0d pulses=%0d exp 1/1", state, retry_seen - r0);
    end
    rf_run = 1'b1;
    wait_state(S_COARSE, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL refloss_resume got=%0d exp=%0d", state, S_COARSE); end
  endtask

  task automatic test_en_drop;
    bit ok; int lr, r0;
    do_reset(0);
    en = 1'b1; rf_run = 1'b1;
    wait_state(S_FINE, 14 * PER, ok);
    rf_run = 1'b0;
    lr = last_rise_cyc;
    r0 = retry_seen;
    for (int i = 0; i < 1100 && cyc < lr + 1027; i++) @(negedge clk);
    checks++;
    if (!ok || state !== S_FINE) begin failures++; $display("FAIL endrop_pre got ok=%0d st=%0d exp 1/3", ok, state); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, retry, step} !== {S_IDLE, 1'b0, 8'h00}) begin
      failures++; $display("FAIL endrop_idle got st=%0d rty=%b step=%h exp 0/0/00", state, retry, step);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ((retry_seen - r0) !== 0) begin failures++; $display("FAIL endrop_no_retry got=%0d exp=0", retry_seen - r0); end
  endtask

  task automatic test_async_reset;
    bit ok;
    do_reset(100);
    en = 1'b1; rf_run = 1'b1;
    wait_state(S_COARSE, 300, ok);
    for (int i = 0; i < 3 * PER && err !== 12'd100; i++) @(negedge clk);
    checks++;
    if (state !== S_COARSE || err !== 12'd100) begin
      failures++; $display("FAIL async_pre got st=%0d err=%0d exp 2/100", state, err);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, step, adpll_rst, locked, err, retry} !== {S_IDLE, 8'h00, 1'b1, 1'b0, 12'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got st=%0d step=%h arst=%b lk=%b err=%0d rty=%b exp 0/00/1/0/0/0",
               state, step, adpll_rst, locked, err, retry);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; rf_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_unlock();
    test_acq_timeout();
    test_ref_loss();
    test_en_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
